// File: rtl/dc_mem_engine.sv
// rtl/dc_mem_engine.sv - data cursors plus block stream engine sharing one main-memory port
module dc_mem_engine #(
  parameter int MAIN_ADDR_WIDTH = 32,
  parameter int WORD_WIDTH      = 32,
  parameter int DC_COUNT        = 4,
  parameter int STRIDE_WIDTH    = 8,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                op_valid,
  output logic                                op_ready,
  input  logic [2:0]                          op_kind,
  input  logic [$clog2(DC_COUNT)-1:0]         op_choice,
  input  logic [WORD_WIDTH-1:0]               op_value,
  input  logic [STRIDE_WIDTH-1:0]             op_stride,
  output logic                                rd_valid,
  output logic [WORD_WIDTH-1:0]               rd_data,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [MAIN_ADDR_WIDTH-1:0]          mem_addr,
  output logic [WORD_WIDTH-1:0]               mem_wdata,
  input  logic                                mem_ack,
  input  logic [WORD_WIDTH-1:0]               mem_rdata,
  input  logic                                stream_start,
  input  logic                                stream_dir,
  input  logic [MAIN_ADDR_WIDTH-1:0]          stream_base,
  input  logic [LEN_WIDTH-1:0]                stream_len,
  input  logic                                stream_in_valid,
  output logic                                stream_in_ready,
  input  logic [WORD_WIDTH-1:0]               stream_in_value,
  output logic                                stream_out_valid,
  input  logic                                stream_out_ready,
  output logic [WORD_WIDTH-1:0]               stream_out_value,
  output logic                                stream_busy,
  output logic                                stream_done,
  output logic [DC_COUNT*MAIN_ADDR_WIDTH-1:0] dc_addrs,
  output logic [DC_COUNT-1:0]                 dc_dirty
);

  localparam int IDX_W = $clog2(DC_COUNT);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SETF  = 3'd2;
  localparam logic [2:0] OP_SETB  = 3'd3;
  localparam logic [2:0] OP_SKIP  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CORE_MEM,
    ST_STREAM_MEM,
    ST_STREAM_WAIT
  } state_e;

  state_e state_q, state_d;

  // Cursor file
  logic [MAIN_ADDR_WIDTH-1:0] cur_addr_q   [DC_COUNT];
  logic [STRIDE_WIDTH-1:0]    cur_stride_q [DC_COUNT];
  logic [DC_COUNT-1:0]        cur_back_q;
  logic [DC_COUNT-1:0]        cur_dirty_q;

  // Single cursor write port: only one cursor changes per cycle
  logic                       cur_we;
  logic [IDX_W-1:0]           cur_idx;
  logic [MAIN_ADDR_WIDTH-1:0] cur_addr_d;
  logic [STRIDE_WIDTH-1:0]    cur_stride_d;
  logic                       cur_back_d;
  logic                       cur_dirty_d;

  logic [MAIN_ADDR_WIDTH-1:0] sel_addr;
  logic [MAIN_ADDR_WIDTH-1:0] sel_step;
  logic [MAIN_ADDR_WIDTH-1:0] sel_next;
  logic                       sel_back;

  // Memory access holding registers and core op bookkeeping
  logic [IDX_W-1:0]           op_idx_q, op_idx_d;
  logic [MAIN_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                       mem_we_q, mem_we_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [WORD_WIDTH-1:0]      rd_data_q, rd_data_d;

  // Stream engine
  logic                       s_busy_q, s_busy_d;
  logic                       s_dir_q, s_dir_d;
  logic [MAIN_ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [LEN_WIDTH-1:0]       s_cnt_q, s_cnt_d;
  logic                       s_done_q, s_done_d;
  logic [WORD_WIDTH-1:0]      sout_value_q, sout_value_d;
  logic                       word_done;

  // In CORE_MEM the cursor being updated is the one latched at accept
  assign cur_idx  = (state_q == ST_CORE_MEM) ? op_idx_q : op_choice;
  assign sel_addr = cur_addr_q[cur_idx];
  assign sel_step = MAIN_ADDR_WIDTH'(cur_stride_q[cur_idx]);
  assign sel_back = cur_back_q[cur_idx];
  assign sel_next = sel_back ? (sel_addr - sel_step) : (sel_addr + sel_step);

  // A pending done pulse holds off the core for one cycle
  assign op_ready = (state_q == ST_IDLE) && !s_done_q;

  // Next-state, access setup, cursor updates and stream bookkeeping
  always_comb begin
    state_d         = state_q;
    op_idx_d        = op_idx_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_we_d        = mem_we_q;
    rd_valid_d      = 1'b0;
    rd_data_d       = rd_data_q;
    s_busy_d        = s_busy_q;
    s_dir_d         = s_dir_q;
    s_addr_d        = s_addr_q;
    s_cnt_d         = s_cnt_q;
    s_done_d        = 1'b0;
    sout_value_d    = sout_value_q;
    cur_we          = 1'b0;
    cur_addr_d      = sel_addr;
    cur_stride_d    = cur_stride_q[cur_idx];
    cur_back_d      = sel_back;
    cur_dirty_d     = cur_dirty_q[cur_idx];
    stream_in_ready = 1'b0;
    word_done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready) begin
          case (op_kind)
            OP_READ, OP_WRITE: begin
              op_idx_d    = op_choice;
              mem_we_d    = (op_kind == OP_WRITE);
              mem_wdata_d = op_value;
              // Backward cursors pre-decrement, forward cursors post-increment
              mem_addr_d  = sel_back ? sel_next : sel_addr;
              state_d     = ST_CORE_MEM;
            end
            OP_SETF, OP_SETB: begin
              cur_we       = 1'b1;
              cur_addr_d   = MAIN_ADDR_WIDTH'(op_value);
              cur_back_d   = (op_kind == OP_SETB);
              cur_stride_d = (op_stride == '0) ? STRIDE_WIDTH'(1) : op_stride;
              cur_dirty_d  = 1'b0;
            end
            OP_SKIP: begin
              cur_we     = 1'b1;
              cur_addr_d = sel_next;
            end
            default: ;
          endcase
        end else if (s_busy_q && !op_valid) begin
          if (!s_dir_q) begin
            stream_in_ready = 1'b1;
            if (stream_in_valid) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = stream_in_value;
              mem_addr_d  = s_addr_q;
              state_d     = ST_STREAM_MEM;
            end
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = s_addr_q;
            state_d    = ST_STREAM_MEM;
          end
        end
        if (stream_start && !s_busy_q) begin
          if (stream_len == '0) begin
            s_done_d = 1'b1;
          end else begin
            s_busy_d = 1'b1;
            s_dir_d  = stream_dir;
            s_addr_d = stream_base;
            s_cnt_d  = stream_len;
          end
        end
      end
      ST_CORE_MEM: begin
        if (mem_ack) begin
          cur_we      = 1'b1;
          cur_addr_d  = sel_next;
          cur_dirty_d = cur_dirty_q[cur_idx] | mem_we_q;
          rd_valid_d  = !mem_we_q;
          rd_data_d   = mem_rdata;
          state_d     = ST_IDLE;
        end
      end
      ST_STREAM_MEM: begin
        if (mem_ack) begin
          if (mem_we_q) begin
            word_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            sout_value_d = mem_rdata;
            state_d      = ST_STREAM_WAIT;
          end
        end
      end
      ST_STREAM_WAIT: begin
        if (stream_out_ready) begin
          word_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (word_done) begin
      s_addr_d = s_addr_q + MAIN_ADDR_WIDTH'(1);
      s_cnt_d  = s_cnt_q - LEN_WIDTH'(1);
      if (s_cnt_q == LEN_WIDTH'(1)) begin
        s_busy_d = 1'b0;
        s_done_d = 1'b1;
      end
    end
  end

  // FSM state, access registers and stream engine registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_idx_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      s_busy_q     <= 1'b0;
      s_dir_q      <= 1'b0;
      s_addr_q     <= '0;
      s_cnt_q      <= '0;
      s_done_q     <= 1'b0;
      sout_value_q <= '0;
    end else begin
      state_q      <= state_d;
      op_idx_q     <= op_idx_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      s_busy_q     <= s_busy_d;
      s_dir_q      <= s_dir_d;
      s_addr_q     <= s_addr_d;
      s_cnt_q      <= s_cnt_d;
      s_done_q     <= s_done_d;
      sout_value_q <= sout_value_d;
    end
  end

  // Cursor file: reset to forward, stride 1, clean at address 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DC_COUNT; i++) begin
        cur_addr_q[i]   <= '0;
        cur_stride_q[i] <= STRIDE_WIDTH'(1);
      end
      cur_back_q  <= '0;
      cur_dirty_q <= '0;
    end else if (cur_we) begin
      cur_addr_q[cur_idx]   <= cur_addr_d;
      cur_stride_q[cur_idx] <= cur_stride_d;
      cur_back_q[cur_idx]   <= cur_back_d;
      cur_dirty_q[cur_idx]  <= cur_dirty_d;
    end
  end

  for (genvar g = 0; g < DC_COUNT; g++) begin : g_dc_addrs
    assign dc_addrs[g*MAIN_ADDR_WIDTH +: MAIN_ADDR_WIDTH] = cur_addr_q[g];
  end

  assign dc_dirty         = cur_dirty_q;
  assign mem_req          = (state_q == ST_CORE_MEM) || (state_q == ST_STREAM_MEM);
  assign mem_we           = mem_req && mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign stream_out_valid = (state_q == ST_STREAM_WAIT);
  assign stream_out_value = sout_value_q;
  assign stream_busy      = s_busy_q;
  assign stream_done      = s_done_q;

endmodule

// File: tb/tb_dc_mem_engine.sv
// tb/tb_dc_mem_engine.sv - directed self-checking bench for dc_mem_engine
module tb_dc_mem_engine;

  localparam logic [31:0] KEY = 32'hC0DE_0000;
  localparam logic [2:0] K_READ = 3'd0, K_WRITE = 3'd1, K_SETF = 3'd2, K_SETB = 3'd3, K_SKIP = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, op_valid, op_ready;
  logic [2:0]   op_kind;
  logic [1:0]   op_choice;
  logic [31:0]  op_value;
  logic [7:0]   op_stride;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         stream_start, stream_dir;
  logic [31:0]  stream_base;
  logic [15:0]  stream_len;
  logic         stream_in_valid, stream_in_ready;
  logic [31:0]  stream_in_value;
  logic         stream_out_valid, stream_out_ready;
  logic [31:0]  stream_out_value;
  logic         stream_busy, stream_done;
  logic [127:0] dc_addrs;
  logic [3:0]   dc_dirty;
  logic         ack_auto, ack_force;

  int checks = 0;
  int failures = 0;

  dc_mem_engine dut (
    .clk(clk), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind), .op_choice(op_choice),
    .op_value(op_value), .op_stride(op_stride),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stream_start(stream_start), .stream_dir(stream_dir), .stream_base(stream_base),
    .stream_len(stream_len),
    .stream_in_valid(stream_in_valid), .stream_in_ready(stream_in_ready),
    .stream_in_value(stream_in_value),
    .stream_out_valid(stream_out_valid), .stream_out_ready(stream_out_ready),
    .stream_out_value(stream_out_value),
    .stream_busy(stream_busy), .stream_done(stream_done),
    .dc_addrs(dc_addrs), .dc_dirty(dc_dirty)
  );

  // Zero-wait memory whose read data is a fixed function of the address
  assign mem_ack   = (ack_auto && mem_req) || ack_force;
  assign mem_rdata = mem_addr ^ KEY;

  logic [31:0] acc_addr[$];
  logic        acc_we[$];
  logic [31:0] acc_data[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (reset_n && mem_req && mem_ack) begin
      acc_addr.push_back(mem_addr);
      acc_we.push_back(mem_we);
      acc_data.push_back(mem_wdata);
    end
    if (stream_done) done_cnt++;
  end

  function automatic logic [31:0] cur(input int i);
    return dc_addrs[i*32 +: 32];
  endfunction

  task automatic issue_op(input logic [2:0] kind, input logic [1:0] ch,
                          input logic [31:0] val, input logic [7:0] str);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b1; op_kind = kind; op_choice = ch; op_value = val; op_stride = str;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (op_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL op_accept_timeout kind=%0d got=no_accept exp=accept", kind);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; op_valid = 1'b0; op_kind = '0; op_choice = '0; op_value = '0; op_stride = '0;
    stream_start = 1'b0; stream_dir = 1'b0; stream_base = '0; stream_len = '0;
    stream_in_valid = 1'b0; stream_in_value = '0; stream_out_ready = 1'b0;
    ack_auto = 1'b1; ack_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (dc_addrs !== '0) begin failures++; $display("FAIL reset_dc_addrs got=%h exp=0", dc_addrs); end
    checks++; if (dc_dirty !== 4'b0) begin failures++; $display("FAIL reset_dc_dirty got=%b exp=0", dc_dirty); end
    checks++; if ({rd_valid, stream_busy, stream_done, stream_in_ready, stream_out_valid} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {rd_valid, stream_busy, stream_done, stream_in_ready, stream_out_valid});
    end
  endtask

  task automatic test_read_fwd;
    issue_op(K_SETF, 2'd1, 32'h100, 8'd4);
    @(negedge clk);
    checks++; if (op_ready !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL setf_no_access got=ready%b req%b exp=ready1 req0", op_ready, mem_req); end
    checks++; if (cur(1) !== 32'h100) begin failures++; $display("FAIL setf_addr got=%h exp=00000100", cur(1)); end
    for (int n = 0; n < 2; n++) begin
      issue_op(K_READ, 2'd1, 32'h0, 8'd0);
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 + 32'(n*4)) begin
        failures++; $display("FAIL read_access%0d got=req%b we%b addr%h exp=req1 we0 addr%h", n, mem_req, mem_we, mem_addr, 32'h100 + 32'(n*4));
      end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL read_early_valid%0d got=%b exp=0", n, rd_valid); end
      @(negedge clk);
      checks++; if (rd_valid !== 1'b1 || rd_data !== ((32'h100 + 32'(n*4)) ^ KEY)) begin
        failures++; $display("FAIL read_data%0d got=v%b %h exp=v1 %h", n, rd_valid, rd_data, (32'h100 + 32'(n*4)) ^ KEY);
      end
    end
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL read_valid_pulse got=%b exp=0", rd_valid); end
    checks++; if (cur(1) !== 32'h108) begin failures++; $display("FAIL read_cursor got=%h exp=00000108", cur(1)); end
  endtask

  task automatic test_write_back;
    logic [31:0] wv [2];
    wv[0] = 32'hAA; wv[1] = 32'hBB;
    issue_op(K_SETB, 2'd2, 32'h200, 8'd1);
    for (int n = 0; n < 2; n++) begin
      issue_op(K_WRITE, 2'd2, wv[n], 8'd0);
      @(negedge clk);
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h1FF - 32'(n) || mem_wdata !== wv[n]) begin
        failures++; $display("FAIL write_access%0d got=we%b addr%h data%h exp=we1 addr%h data%h", n, mem_we, mem_addr, mem_wdata, 32'h1FF - 32'(n), wv[n]);
      end
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL write_no_rd_valid%0d got=%b exp=0", n, rd_valid); end
    end
    checks++; if (cur(2) !== 32'h1FE) begin failures++; $display("FAIL write_cursor got=%h exp=000001fe", cur(2)); end
    checks++; if (dc_dirty !== 4'b0100) begin failures++; $display("FAIL write_dirty got=%b exp=0100", dc_dirty); end
    issue_op(K_SETF, 2'd2, 32'h300, 8'd0);
    @(negedge clk);
    checks++; if (dc_dirty !== 4'b0000) begin failures++; $display("FAIL setf_clears_dirty got=%b exp=0000", dc_dirty); end
    issue_op(K_READ, 2'd2, 32'h0, 8'd0);
    @(negedge clk);
    checks++; if (mem_addr !== 32'h300) begin failures++; $display("FAIL stride0_access got=%h exp=00000300", mem_addr); end
    @(negedge clk);
    checks++; if (cur(2) !== 32'h301) begin failures++; $display("FAIL stride0_as_1 got=%h exp=00000301", cur(2)); end
  endtask

  task automatic test_wrap;
    issue_op(K_SETF, 2'd3, 32'hFFFF_FFFE, 8'd4);
    issue_op(K_SKIP, 2'd3, 32'h0, 8'd0);
    @(negedge clk);
    checks++; if (cur(3) !== 32'h0000_0002) begin failures++; $display("FAIL skip_wrap_fwd got=%h exp=00000002", cur(3)); end
    checks++; if (mem_req !== 1'b0 || op_ready !== 1'b1) begin failures++; $display("FAIL skip_no_access got=req%b ready%b exp=req0 ready1", mem_req, op_ready); end
    issue_op(K_SETB, 2'd0, 32'h1, 8'd2);
    issue_op(K_SKIP, 2'd0, 32'h0, 8'd0);
    @(negedge clk);
    checks++; if (cur(0) !== 32'hFFFF_FFFF) begin failures++; $display("FAIL skip_wrap_back got=%h exp=ffffffff", cur(0)); end
  endtask

  task automatic test_stream_len0;
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    stream_start = 1'b1; stream_dir = 1'b0; stream_base = 32'h70; stream_len = 16'd0;
    @(posedge clk); #1;
    stream_start = 1'b0;
    @(negedge clk);
    checks++; if (stream_done !== 1'b1 || stream_busy !== 1'b0) begin failures++; $display("FAIL len0_done got=done%b busy%b exp=done1 busy0", stream_done, stream_busy); end
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL len0_ready_hold got=%b exp=0", op_ready); end
    @(negedge clk);
    checks++; if (stream_done !== 1'b0 || op_ready !== 1'b1 || stream_busy !== 1'b0) begin
      failures++; $display("FAIL len0_after got=done%b ready%b busy%b exp=done0 ready1 busy0", stream_done, op_ready, stream_busy);
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL len0_pulses got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_stream_in_with_core;
    logic [31:0] words [3];
    int n0, d0, idx;
    logic hs, ohs, fin;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    n0 = acc_addr.size(); d0 = done_cnt; idx = 0; fin = 1'b0;
    @(posedge clk); #1;
    stream_start = 1'b1; stream_dir = 1'b0; stream_base = 32'h40; stream_len = 16'd3;
    @(posedge clk); #1;
    stream_start = 1'b0;
    @(negedge clk);
    checks++; if (stream_busy !== 1'b1) begin failures++; $display("FAIL sin_busy got=%b exp=1", stream_busy); end
    @(posedge clk); #1;
    op_valid = 1'b1; op_kind = K_READ; op_choice = 2'd1;
    stream_in_valid = 1'b1; stream_in_value = words[0];
    @(negedge clk);
    checks++; if (stream_in_ready !== 1'b0 || op_ready !== 1'b1) begin
      failures++; $display("FAIL sin_core_priority got=sin_ready%b op_ready%b exp=0 1", stream_in_ready, op_ready);
    end
    hs = stream_in_valid && stream_in_ready; ohs = op_valid && op_ready;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (ohs) op_valid = 1'b0;
      if (hs) begin
        idx++;
        if (idx < 3) stream_in_value = words[idx];
        else stream_in_valid = 1'b0;
      end
      if (idx == 3 && !stream_busy) fin = 1'b1;
      @(negedge clk);
      hs = stream_in_valid && stream_in_ready; ohs = op_valid && op_ready;
    end
    op_valid = 1'b0; stream_in_valid = 1'b0;
    checks++; if (fin !== 1'b1) begin failures++; $display("FAIL sin_timeout got=words%0d exp=3", idx); end
    repeat (3) @(negedge clk);
    checks++; if (acc_addr.size() - n0 !== 4) begin failures++; $display("FAIL sin_access_count got=%0d exp=4", acc_addr.size() - n0); end
    else begin
      checks++; if (acc_addr[n0] !== 32'h108 || acc_we[n0] !== 1'b0) begin
        failures++; $display("FAIL sin_core_first got=addr%h we%b exp=addr00000108 we0", acc_addr[n0], acc_we[n0]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++; if (acc_addr[n0+1+k] !== 32'h40 + 32'(k) || acc_we[n0+1+k] !== 1'b1 || acc_data[n0+1+k] !== words[k]) begin
          failures++; $display("FAIL sin_write%0d got=addr%h we%b data%h exp=addr%h we1 data%h", k, acc_addr[n0+1+k], acc_we[n0+1+k], acc_data[n0+1+k], 32'h40 + 32'(k), words[k]);
        end
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL sin_done_pulses got=%0d exp=1", done_cnt - d0); end
    checks++; if (stream_busy !== 1'b0) begin failures++; $display("FAIL sin_busy_after got=%b exp=0", stream_busy); end
  endtask

  task automatic test_stream_out_backpressure;
    logic [31:0] got[$];
    int n0, d0;
    logic seen, fin;
    n0 = acc_addr.size(); d0 = done_cnt; seen = 1'b0; fin = 1'b0;
    stream_out_ready = 1'b0;
    @(posedge clk); #1;
    stream_start = 1'b1; stream_dir = 1'b1; stream_base = 32'h80; stream_len = 16'd2;
    @(posedge clk); #1;
    stream_start = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (stream_out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL sout_valid_timeout got=0 exp=1"); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (stream_out_valid !== 1'b1 || stream_out_value !== (32'h80 ^ KEY) || mem_req !== 1'b0) begin
        failures++; $display("FAIL sout_hold%0d got=v%b %h req%b exp=v1 %h req0", k, stream_out_valid, stream_out_value, mem_req, 32'h80 ^ KEY);
      end
      @(posedge clk); #1;
      stream_start = (k == 1);
      stream_base = 32'h900; stream_len = 16'd5;
      @(negedge clk);
    end
    stream_start = 1'b0;
    @(posedge clk); #1;
    stream_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (stream_out_valid && stream_out_ready) got.push_back(stream_out_value);
      if (stream_done) fin = 1'b1;
    end
    stream_out_ready = 1'b0;
    checks++; if (fin !== 1'b1) begin failures++; $display("FAIL sout_done_timeout got=0 exp=1"); end
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL sout_count got=%0d exp=2", got.size()); end
    else begin
      checks++; if (got[0] !== (32'h80 ^ KEY) || got[1] !== (32'h81 ^ KEY)) begin
        failures++; $display("FAIL sout_values got=%h %h exp=%h %h", got[0], got[1], 32'h80 ^ KEY, 32'h81 ^ KEY);
      end
    end
    repeat (2) @(negedge clk);
    checks++; if (acc_addr.size() - n0 !== 2) begin failures++; $display("FAIL sout_reads got=%0d exp=2", acc_addr.size() - n0); end
    else begin
      checks++; if (acc_addr[n0] !== 32'h80 || acc_addr[n0+1] !== 32'h81 || acc_we[n0] !== 1'b0 || acc_we[n0+1] !== 1'b0) begin
        failures++; $display("FAIL sout_read_addrs got=%h %h exp=00000080 00000081", acc_addr[n0], acc_addr[n0+1]);
      end
    end
    checks++; if (done_cnt - d0 !== 1 || stream_busy !== 1'b0) begin
      failures++; $display("FAIL sout_done got=pulses%0d busy%b exp=pulses1 busy0", done_cnt - d0, stream_busy);
    end
  endtask

  task automatic test_reset_mid_access;
    issue_op(K_SETF, 2'd1, 32'h500, 8'd1);
    ack_auto = 1'b0;
    issue_op(K_READ, 2'd1, 32'h0, 8'd0);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin failures++; $display("FAIL rst_mid_req got=req%b addr%h exp=req1 addr00000500", mem_req, mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1 || mem_req !== 1'b0 || dc_addrs !== '0) begin
      failures++; $display("FAIL rst_async got=ready%b req%b c1=%h exp=ready1 req0 c1=0", op_ready, mem_req, cur(1));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0 || op_ready !== 1'b1 || dc_addrs !== '0 || mem_req !== 1'b0) begin
        failures++; $display("FAIL rst_stale_ack%0d got=rv%b ready%b req%b c1=%h exp=rv0 ready1 req0 c1=0", k, rd_valid, op_ready, mem_req, cur(1));
      end
    end
    ack_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_fwd();
    test_write_back();
    test_wrap();
    test_stream_len0();
    test_stream_in_with_core();
    test_stream_out_backpressure();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_mem_engine.md
Name: dc_mem_engine

Overview:
- Registered, parametrised successor to the combinational cursor/memory steering logic.
- Owns DC_COUNT data cursors (address, direction, stride, dirty flag) plus one block stream engine; arbitrates both onto a single main-memory port.
- Sits between core decode and main memory.
- Core issues cursor ops via valid/ready; stream peripherals move blocks without core involvement.

Parameters:
MAIN_ADDR_WIDTH, 32, main memory address width
WORD_WIDTH, 32, data word width
DC_COUNT, 4, number of data cursors (power of two, >=2)
STRIDE_WIDTH, 8, per-cursor stride width (unsigned)
LEN_WIDTH, 16, stream length counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  core op request
op_ready  out  1  engine accepts op this cycle
op_kind  in  3  0 READ, 1 WRITE, 2 SETF, 3 SETB, 4 SKIP; others no-op
op_choice  in  $clog2(DC_COUNT)  cursor index
op_value  in  WORD_WIDTH  SET address (low MAIN_ADDR_WIDTH bits) / WRITE data
op_stride  in  STRIDE_WIDTH  stride loaded by SETF/SETB
rd_valid  out  1  READ data valid pulse
rd_data  out  WORD_WIDTH  READ data
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  MAIN_ADDR_WIDTH  memory address
mem_wdata  out  WORD_WIDTH  write data
mem_ack  in  1  request completes this cycle
mem_rdata  in  WORD_WIDTH  read data, valid with mem_ack
stream_start  in  1  start block transfer (ignored while busy)
stream_dir  in  1  0 stream-in (writes memory), 1 stream-out (reads memory)
stream_base  in  MAIN_ADDR_WIDTH  first address
stream_len  in  LEN_WIDTH  word count
stream_in_valid / stream_in_ready  in / out  1  inbound handshake
stream_in_value  in  WORD_WIDTH  inbound word
stream_out_valid / stream_out_ready  out / in  1  outbound handshake
stream_out_value  out  WORD_WIDTH  outbound word
stream_busy  out  1  transfer active
stream_done  out  1  one-cycle pulse after last word
dc_addrs  out  DC_COUNT*MAIN_ADDR_WIDTH  cursor addresses
dc_dirty  out  DC_COUNT  cursor written since last SET

Behaviour:
- Reset: all cursors addr 0, direction fwd, stride 1, dirty 0. op_ready=1; all other outputs 0; stream idle; counters 0.
- FSM states: IDLE, CORE_MEM, STREAM_MEM, STREAM_WAIT.
- Op acceptance: op accepted when op_valid&&op_ready. op_ready=1 only in IDLE and only when no stream_done is pending.
- SETF/SETB/SKIP: complete in the accept cycle with no memory access; op_ready stays 1.
  - SETF/SETB: addr<=op_value, direction<=fwd/back, stride<=op_stride (0 treated as 1), dirty<=0.
  - SKIP: advances the cursor by ±stride.
- READ/WRITE access address and cursor update:
  - Forward: access at addr, then addr+=stride.
  - Backward: access at addr-stride, then addr-=stride.
  - Cursor update happens on mem_ack.
  - WRITE sets dirty.
- READ/WRITE timing: mem_req asserts the cycle after accept (state CORE_MEM); address/data held stable until mem_ack.
- READ result: rd_valid pulses the cycle after mem_ack with rd_data=mem_rdata.
- Minimum READ latency: accept to rd_valid = 2 cycles with zero-wait memory.
- Arithmetic: addresses wrap modulo 2^MAIN_ADDR_WIDTH. Stride zero-extended.
- Stream start: stream_start in IDLE with stream_len!=0 loads addr/count and sets stream_busy. stream_len=0: stream_done pulses next cycle, busy never set.
- Stream-in: stream_in_ready=1 only in IDLE while busy with no core op pending. A handshake latches the word and moves to STREAM_MEM (write).
- Stream-out: STREAM_MEM read; on mem_ack, data goes to STREAM_WAIT with stream_out_valid held until stream_out_ready.
- Stream bookkeeping: each completed word does addr+=1, count-=1. On count reaching 0: busy drops, stream_done pulses.
- Arbitration: in IDLE, a pending core op has priority over the next stream word. An in-flight access is never pre-empted.
- stream_start while busy: ignored.
- Reset mid-operation: everything returns to reset values immediately. An outstanding mem_ack after reset is ignored.

Test Plan:
- SETF c1=0x100 stride 4; READ c1 x2 with zero-wait mem -> mem_addr 0x100 then 0x104; rd_valid 2 cycles after each accept; c1=0x108.
- SETB c2=0x200 stride 1; WRITE 0xAA, WRITE 0xBB -> writes at 0x1FF, 0x1FE; c2=0x1FE; dc_dirty[2]=1; SETF c2 clears dirty.
- Cursor at 0xFFFFFFFE fwd stride 4; SKIP -> addr 0x00000002 (wrap).
- Stream-in base 0x40 len 3, core READ issued mid-stream -> core access granted first; memory writes 0x40-0x42 in order; stream_done pulses once; busy low afterwards.
- Stream-out len 2 with stream_out_ready held low 5 cycles -> stream_out_valid/value stable; no further mem_req until accepted.
- reset_n low during CORE_MEM with mem_ack 1 cycle after release -> no rd_valid, cursors 0, op_ready=1.
